// File: rtl/jpeg_byte_streamer.sv
// rtl/jpeg_byte_streamer.sv - buffers encoder words and serialises them into a byte stream
// with an end-of-frame marker on the final byte.

module jpeg_byte_streamer_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          wr_en, rd_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];
  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + {AW'(0), wr_en} - {AW'(0), rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module jpeg_byte_streamer #(
  parameter int FIFO_DEPTH = 64,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   word_in,
  input  logic                          word_valid_in,
  input  logic                          image_valid_in,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid_out,
  input  logic                          byte_ready_in,
  output logic                          byte_last_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  output logic [19:0]                   byte_count_out,
  output logic [15:0]                   frame_count_out
);
  typedef enum logic {S_EMPTY, S_SENDING} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [32:0] sh_q, sh_d;
  logic [31:0] h_q, h_d;
  logic        h_full_q, h_full_d;
  logic        eop_pending_q, eop_pending_d;
  logic        image_valid_q;
  logic        overflow_q, overflow_d;
  logic [19:0] byte_count_q, byte_count_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        rise, push, pop, xfer, idle, last_xfer;
  logic [32:0] push_data, fifo_data;
  logic        fifo_empty, fifo_full;

  jpeg_byte_streamer_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level_out)
  );

  assign rise = image_valid_in & ~image_valid_q;

  // H delays every word by one so the frame's final word is still on hand when EOP arrives.
  always_comb begin
    h_d           = h_q;
    h_full_d      = h_full_q;
    push          = 1'b0;
    push_data     = {1'b0, h_q};
    eop_pending_d = eop_pending_q | rise;
    if (word_valid_in) begin
      push     = h_full_q;
      h_d      = word_in;
      h_full_d = 1'b1;
    end else if (eop_pending_q) begin
      push          = h_full_q;
      push_data     = {1'b1, h_q};
      h_full_d      = 1'b0;
      eop_pending_d = rise;
    end
  end

  assign byte_valid_out = (state_q == S_SENDING);
  assign byte_out       = MSB_FIRST ? sh_q[31:24] : sh_q[7:0];
  assign byte_last_out  = byte_valid_out & sh_q[32] & (idx_q == 2'd3);
  assign xfer           = byte_valid_out & byte_ready_in;
  assign idle           = (state_q == S_EMPTY) | (xfer & (idx_q == 2'd3));
  assign pop            = idle & ~fifo_empty;
  assign last_xfer      = xfer & byte_last_out;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    if (pop) begin
      state_d = S_SENDING;
      idx_d   = 2'd0;
      sh_d    = fifo_data;
    end else if (idle) begin
      state_d = S_EMPTY;
    end else if (xfer) begin
      idx_d = idx_q + 2'd1;
      if (MSB_FIRST) sh_d = {sh_q[32], sh_q[23:0], 8'h00};
      else           sh_d = {sh_q[32], 8'h00, sh_q[31:8]};
    end
  end

  always_comb begin
    overflow_d    = overflow_q | (push & fifo_full);
    frame_count_d = frame_count_q + 16'(last_xfer);
    byte_count_d  = byte_count_q;
    if (last_xfer)  byte_count_d = 20'd0;
    else if (xfer)  byte_count_d = byte_count_q + 20'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_EMPTY;
      idx_q         <= 2'd0;
      sh_q          <= '0;
      h_q           <= '0;
      h_full_q      <= 1'b0;
      eop_pending_q <= 1'b0;
      image_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      byte_count_q  <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sh_q          <= sh_d;
      h_q           <= h_d;
      h_full_q      <= h_full_d;
      eop_pending_q <= eop_pending_d;
      image_valid_q <= image_valid_in;
      overflow_q    <= overflow_d;
      byte_count_q  <= byte_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign overflow_out    = overflow_q;
  assign byte_count_out  = byte_count_q;
  assign frame_count_out = frame_count_q;
endmodule
